// File: rtl/sample_printer_pkg.sv
// rtl/sample_printer_pkg.sv - shared state encoding and message constants for sample_printer
package sample_printer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ROMWAIT,
      SEND,
      GUARD
   } state_t;

   localparam int CHAR_COUNT = 12;
   localparam logic [3:0] LAST_IDX   = 4'(CHAR_COUNT - 1);
   localparam logic [3:0] HEX_HI_IDX = 4'd8;
   localparam logic [3:0] HEX_LO_IDX = 4'd9;
   localparam logic [3:0] SUFFIX_IDX = 4'd10;

   localparam int ROM_PREFIX_LAST  = 7;
   localparam int ROM_SUFFIX_FIRST = 8;
   localparam int ROM_SUFFIX_LAST  = 9;

   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_UPPER_A = 8'h41;
   localparam logic [7:0] ASCII_LOWER_A = 8'h61;

endpackage

// File: rtl/sample_printer_nibble_to_ascii.sv
// rtl/sample_printer_nibble_to_ascii.sv - combinational 4-bit nibble to ASCII hex digit
module sample_printer_nibble_to_ascii
   import sample_printer_pkg::*;
#(
   parameter bit UPPERCASE = 1'b1
) (
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   localparam logic [7:0] LETTER_BASE = UPPERCASE ? ASCII_UPPER_A : ASCII_LOWER_A;

   always_comb begin
      if (nibble < 4'd10) begin
         ascii = ASCII_ZERO + {4'h0, nibble};
      end else begin
         ascii = LETTER_BASE + {4'h0, nibble} - 8'd10;
      end
   end

endmodule

// File: rtl/sample_printer.sv
// rtl/sample_printer.sv - formats a captured byte as "Data: 0xHH\n\r" and streams it to the UART
module sample_printer
   import sample_printer_pkg::*;
#(
   parameter bit UPPERCASE    = 1'b1,
   parameter int PREFIX_LAST  = ROM_PREFIX_LAST,
   parameter int SUFFIX_FIRST = ROM_SUFFIX_FIRST,
   parameter int SUFFIX_LAST  = ROM_SUFFIX_LAST
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sample_in,
   input  logic       sample_valid,
   output logic       busy,
   output logic       dropped,
   output logic [3:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic [7:0] tx_data,
   output logic       new_tx_data,
   input  logic       tx_busy
);

   state_t     state, state_next;
   logic [3:0] idx, idx_next;
   logic [7:0] sample, sample_next;
   logic       busy_next, dropped_next, new_tx_data_next;
   logic [3:0] rom_addr_next;
   logic [7:0] tx_data_next;
   logic [7:0] hex_char;
   logic       is_hex;

   // rom_addr is loaded as FETCH is entered so the registered ROM data is ready in ROMWAIT
   function automatic logic [3:0] addr_for(input logic [3:0] i, input logic [3:0] hold);
      if (i <= 4'(PREFIX_LAST)) begin
         return i;
      end else if (i >= SUFFIX_IDX && i <= LAST_IDX) begin
         return 4'(SUFFIX_FIRST) + (i - SUFFIX_IDX);
      end else begin
         return hold;
      end
   endfunction

   assign is_hex = (idx == HEX_HI_IDX) || (idx == HEX_LO_IDX);

   sample_printer_nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_hex (
      .nibble (idx[0] ? sample[3:0] : sample[7:4]),
      .ascii  (hex_char)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (sample_valid) state_next = FETCH;
         FETCH:   state_next = is_hex ? SEND : ROMWAIT;
         ROMWAIT: state_next = SEND;
         SEND:    if (!tx_busy) state_next = GUARD;
         GUARD:   state_next = (idx == LAST_IDX) ? IDLE : FETCH;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      idx_next         = idx;
      sample_next      = sample;
      busy_next        = busy;
      rom_addr_next    = rom_addr;
      tx_data_next     = tx_data;
      new_tx_data_next = 1'b0;
      dropped_next     = sample_valid && (state != IDLE);
      case (state)
         IDLE: begin
            if (sample_valid) begin
               sample_next   = sample_in;
               idx_next      = 4'd0;
               busy_next     = 1'b1;
               rom_addr_next = addr_for(4'd0, rom_addr);
            end
         end
         FETCH:   if (is_hex) tx_data_next = hex_char;
         ROMWAIT: tx_data_next = rom_data;
         SEND:    if (!tx_busy) new_tx_data_next = 1'b1;
         GUARD: begin
            if (idx == LAST_IDX) begin
               busy_next = 1'b0;
            end else begin
               idx_next      = idx + 4'd1;
               rom_addr_next = addr_for(idx + 4'd1, rom_addr);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= 4'd0;
         sample      <= 8'h00;
         busy        <= 1'b0;
         dropped     <= 1'b0;
         rom_addr    <= 4'd0;
         tx_data     <= 8'h00;
         new_tx_data <= 1'b0;
      end else begin
         idx         <= idx_next;
         sample      <= sample_next;
         busy        <= busy_next;
         dropped     <= dropped_next;
         rom_addr    <= rom_addr_next;
         tx_data     <= tx_data_next;
         new_tx_data <= new_tx_data_next;
      end
   end

endmodule

// File: tb/tb_sample_printer.sv
// tb/tb_sample_printer.sv - directed self-checking bench for sample_printer
module tb_sample_printer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sample_in = 8'h00;
   logic       sample_valid = 1'b0;
   logic       busy, dropped, new_tx_data;
   logic [3:0] rom_addr;
   logic [7:0] rom_data;
   logic [7:0] tx_data;
   logic       tx_busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int c0 = 0;
   int hold = 0;
   int busy_cnt = 0;
   int drop_cnt = 0;
   int chg_cnt = 0;
   int fall_cyc = -1;
   logic prev_busy = 1'b0;
   logic [7:0] prev_tx = 8'h00;
   logic [7:0] q[$];
   int strobe_cyc[$];

   sample_printer #(.UPPERCASE(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .busy         (busy),
      .dropped      (dropped),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .tx_data      (tx_data),
      .new_tx_data  (new_tx_data),
      .tx_busy      (tx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // message ROM with one cycle of registered read latency
   always @(posedge clk) begin
      case (rom_addr)
         4'd0: rom_data <= 8'h44;
         4'd1: rom_data <= 8'h61;
         4'd2: rom_data <= 8'h74;
         4'd3: rom_data <= 8'h61;
         4'd4: rom_data <= 8'h3A;
         4'd5: rom_data <= 8'h20;
         4'd6: rom_data <= 8'h30;
         4'd7: rom_data <= 8'h78;
         4'd8: rom_data <= 8'h0A;
         4'd9: rom_data <= 8'h0D;
         default: rom_data <= 8'h40;
      endcase
   end

   // UART model: tx_busy rises the cycle after a strobe and stays for hold cycles
   always @(posedge clk or posedge rst) begin
      if (rst) busy_cnt <= 0;
      else if (new_tx_data && hold > 0) busy_cnt <= hold;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   always @(negedge clk) begin
      if (new_tx_data) begin
         q.push_back(tx_data);
         strobe_cyc.push_back(cyc);
      end
      if (dropped) drop_cnt++;
      if (tx_data !== prev_tx) chg_cnt++;
      prev_tx = tx_data;
      if (prev_busy && !busy) fall_cyc = cyc;
      prev_busy = busy;
   end

   function automatic logic [7:0] hex_of(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
   endfunction

   function automatic logic [7:0] exp_char(input logic [7:0] b, input int i);
      case (i)
         0: return 8'h44;  1: return 8'h61;  2: return 8'h74;  3: return 8'h61;
         4: return 8'h3A;  5: return 8'h20;  6: return 8'h30;  7: return 8'h78;
         8: return hex_of(b[7:4]);
         9: return hex_of(b[3:0]);
         10: return 8'h0A;
         default: return 8'h0D;
      endcase
   endfunction

   task automatic send_sample(input logic [7:0] b);
      @(posedge clk); #1;
      sample_in = b;
      sample_valid = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit, input string name);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk); #1;
         if (!busy) return;
      end
      checks++; errors++;
      $display("FAIL %s timeout: busy still %0b after %0d cycles, required 0", name, busy, limit);
   endtask

   task automatic check_line(input logic [7:0] b, input string name);
      checks++;
      if (q.size() != 12) begin
         errors++;
         $display("FAIL %s count: got %0d strobes, required 12", name, q.size());
      end
      for (int i = 0; i < 12 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== exp_char(b, i)) begin
            errors++;
            $display("FAIL %s char%0d: got %02h, required %02h", name, i, q[i], exp_char(b, i));
         end
      end
   endtask

   task automatic clear_capture();
      q.delete();
      strobe_cyc.delete();
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, dropped, new_tx_data} !== 3'b000 || rom_addr !== 4'd0 || tx_data !== 8'h00) begin
         errors++;
         $display("FAIL reset: busy=%0b dropped=%0b strobe=%0b addr=%0h tx=%02h, required all 0",
                  busy, dropped, new_tx_data, rom_addr, tx_data);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_print_a5();
      clear_capture();
      send_sample(8'hA5);
      wait_idle(200, "a5");
      check_line(8'hA5, "a5");
      checks++;
      if (strobe_cyc.size() < 12 || strobe_cyc[0] != c0 + 4) begin
         errors++;
         $display("FAIL a5 latency: first strobe at %0d, required %0d", strobe_cyc.size() ? strobe_cyc[0] - c0 : -1, 4);
      end
      checks++;
      if (strobe_cyc.size() < 12 || strobe_cyc[11] != c0 + 46) begin
         errors++;
         $display("FAIL a5 throughput: last strobe at %0d, required 46", strobe_cyc.size() == 12 ? strobe_cyc[11] - c0 : -1);
      end
      checks++;
      if (fall_cyc != c0 + 47) begin
         errors++;
         $display("FAIL a5 busy_fall: at %0d, required 47", fall_cyc - c0);
      end
   endtask

   task automatic test_digit_extremes();
      clear_capture();
      send_sample(8'h00);
      wait_idle(200, "x00");
      check_line(8'h00, "x00");
      clear_capture();
      send_sample(8'hFF);
      wait_idle(200, "xff");
      check_line(8'hFF, "xff");
   endtask

   task automatic test_backpressure();
      clear_capture();
      hold = 100;
      chg_cnt = 0;
      send_sample(8'h5A);
      wait_idle(3000, "bp");
      check_line(8'h5A, "bp");
      checks++;
      if (strobe_cyc.size() != 12 || strobe_cyc[11] - strobe_cyc[0] != 11 * 102) begin
         errors++;
         $display("FAIL bp spacing: span %0d, required %0d", strobe_cyc.size() == 12 ? strobe_cyc[11] - strobe_cyc[0] : -1, 11 * 102);
      end
      checks++;
      if (chg_cnt != 12) begin
         errors++;
         $display("FAIL bp tx_stable: tx_data changed %0d times, required 12", chg_cnt);
      end
      repeat (110) @(negedge clk);
      hold = 0;
   endtask

   task automatic test_overrun();
      int n;
      clear_capture();
      drop_cnt = 0;
      send_sample(8'h12);
      n = 0;
      while (q.size() < 5 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      sample_in = 8'h3C;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      wait_idle(200, "ovr");
      check_line(8'h12, "ovr");
      checks++;
      if (drop_cnt != 1) begin
         errors++;
         $display("FAIL ovr dropped: %0d pulses, required 1", drop_cnt);
      end
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || q.size() != 12) begin
         errors++;
         $display("FAIL ovr second_line: busy=%0b strobes=%0d, required 0 and 12", busy, q.size());
      end
   endtask

   task automatic test_reset_mid_line();
      int n;
      clear_capture();
      send_sample(8'h7E);
      n = 0;
      while (q.size() < 3 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, dropped, new_tx_data} !== 3'b000 || rom_addr !== 4'd0 || tx_data !== 8'h00) begin
         errors++;
         $display("FAIL midrst outputs: busy=%0b dropped=%0b strobe=%0b addr=%0h tx=%02h, required all 0",
                  busy, dropped, new_tx_data, rom_addr, tx_data);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_capture();
      send_sample(8'h7E);
      wait_idle(200, "midrst");
      check_line(8'h7E, "midrst");
   endtask

   task automatic test_back_to_back();
      int n;
      clear_capture();
      drop_cnt = 0;
      send_sample(8'h3C);
      n = 0;
      while (q.size() < 12 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      // still in the final GUARD cycle: this sample must be dropped
      sample_in = 8'h99;
      sample_valid = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || dropped !== 1'b1) begin
         errors++;
         $display("FAIL b2b guard_drop: busy=%0b dropped=%0b, required 0 and 1", busy, dropped);
      end
      check_line(8'h3C, "b2b_first");
      clear_capture();
      sample_in = 8'hC3;
      c0 = cyc;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      wait_idle(200, "b2b");
      check_line(8'hC3, "b2b_second");
      checks++;
      if (strobe_cyc.size() == 0 || strobe_cyc[0] != c0 + 4 || drop_cnt != 1) begin
         errors++;
         $display("FAIL b2b accept: first strobe at %0d drops=%0d, required 4 and 1",
                  strobe_cyc.size() ? strobe_cyc[0] - c0 : -1, drop_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_print_a5();
      test_digit_extremes();
      test_backpressure();
      test_overrun();
      test_reset_mid_line();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sample_printer.md
Name: sample_printer

Overview:
- Formats one captured byte as the ASCII line "Data: 0xHH\n\r" and streams it, one character at a time, into the UART transmitter.
- Sits between the byte sampler (upstream) and serial_tx (downstream).
- Drives the address of the message ROM, which has one cycle of registered read latency.
- Generates the two hex digits itself.

Parameters:
- UPPERCASE, 1, 1 emits hex digits A-F; 0 emits a-f.
- PREFIX_LAST, 7, last ROM address of the prefix "Data: 0x".
- SUFFIX_FIRST, 8, first ROM address of the line terminator.
- SUFFIX_LAST, 9, last ROM address of the line terminator.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sample_in  input  8  byte to print; qualified by sample_valid
- sample_valid  input  1  one-cycle strobe: new sample available
- busy  output  1  high while a line is being emitted
- dropped  output  1  one-cycle pulse: sample_valid arrived while busy, and the sample was discarded
- rom_addr  output  4  message ROM address
- rom_data  input  8  ROM character; valid one clk after rom_addr changes
- tx_data  output  8  character to transmit
- new_tx_data  output  1  one-cycle strobe that loads tx_data into the UART
- tx_busy  input  1  UART busy; registered, so it rises the cycle after new_tx_data

Behaviour:
- Reset values (asynchronous, rst=1):
  - state=IDLE, busy=0, dropped=0, rom_addr=0, tx_data=0x00, new_tx_data=0.
  - The sample register clears to 0x00.
  - All outputs are registered.
- States: IDLE, FETCH, ROMWAIT, SEND, GUARD.
- Character sequence (12 characters):
  - idx 0-7: ROM addresses 0..PREFIX_LAST
  - idx 8: high nibble as hex
  - idx 9: low nibble as hex
  - idx 10-11: ROM addresses SUFFIX_FIRST..SUFFIX_LAST
- The character index is a 4-bit counter, 0..11.
- IDLE:
  - On sample_valid, latch sample_in, set idx=0, set busy=1, go to FETCH.
- FETCH:
  - idx<8: rom_addr=idx. idx>=10: rom_addr=SUFFIX_FIRST+(idx-10). Go to ROMWAIT.
  - idx 8/9: compute the hex character into tx_data and go directly to SEND; no ROM access.
- ROMWAIT:
  - One cycle for ROM latency; capture rom_data into tx_data on exit. Go to SEND.
- SEND:
  - If tx_busy=0: pulse new_tx_data for one cycle and go to GUARD.
  - Otherwise hold, with tx_data stable.
- GUARD:
  - One cycle in which tx_busy is ignored, covering its registered rise.
  - If idx=11: return to IDLE with busy=0 (busy falls the cycle after the final strobe).
  - Else: idx+1, go to FETCH.
- Hex conversion: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10) if UPPERCASE, else 0x61+(n-10).
- Throughput: minimum 4 cycles per ROM character and 3 per hex character, with tx_busy low.
- Latency: sample_valid at cycle 0 -> first new_tx_data at cycle 4.
- Boundary conditions:
  - sample_valid in any non-IDLE state: the sample is ignored, dropped pulses for that cycle, and the latched sample is unchanged.
  - sample_valid in the same cycle busy falls (state GUARD with idx=11): the sample is dropped. Acceptance occurs only in IDLE.
  - tx_busy stuck high: the block waits indefinitely in SEND. There is no timeout.
  - Reset mid-line: immediate return to IDLE. A partially sent line is not resumed.
  - The ROM returns "@" for addresses >9. The block never issues those addresses, so "@" must never appear on tx_data.

Decomposition:
- Shared package:
  - state enumeration
  - character-count constant (12)
  - ROM address constants (PREFIX_LAST, SUFFIX_FIRST, SUFFIX_LAST)
  - ASCII constants for '0', 'A', 'a'
- One natural sub-module: nibble_to_ascii (combinational, 4-bit in / 8-bit out, UPPERCASE parameter).
  - Instantiated twice, or muxed once by idx.

Test Plan:
- Print 0xA5: pulse sample_valid with sample_in=0xA5, tx_busy always low.
  -> new_tx_data bytes 44 61 74 61 3A 20 30 78 41 35 0A 0D, in order.
  -> First strobe at cycle 4; busy falls after the 12th strobe.
- Digit extremes: samples 0x00 and 0xFF.
  -> Digits 30 30 and 46 46 (66 66 with UPPERCASE=0).
- Backpressure: a UART model holds tx_busy high for 100 cycles after each strobe.
  -> Exactly 12 strobes, tx_data stable while in SEND, no character duplicated or skipped.
- Overrun: sample_valid with 0x3C during character 5 of a 0x12 line.
  -> dropped pulses once; output line reads "0x12"; no second line starts.
- Reset mid-line: assert rst asynchronously after the 3rd strobe, release, then send sample 0x7E.
  -> Outputs reach reset values immediately; a complete, correct line "Data: 0x7E\n\r" follows.
- Back-to-back: sample_valid on the first IDLE cycle after busy falls.
  -> The sample is accepted and its line is emitted complete.
